// File: rtl/pattern_match_ctrl_if.sv
// rtl/pattern_match_ctrl_if.sv - config/control and serial-bit bundle for pattern_match_ctrl
interface pattern_match_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             w;
    logic             w_valid;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_we, cfg_pattern, cfg_target, start, abort, w, w_valid,
        input  z, match_cnt, busy, done
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_target, start, abort, w, w_valid,
        output z, match_cnt, busy, done
    );
endinterface

// File: rtl/pattern_match_ctrl.sv
// rtl/pattern_match_ctrl.sv - run-controlled programmable serial pattern detector
module pattern_match_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_match_ctrl_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_n;
    logic [PAT_W-1:0]  r_pattern, r_shift, w_shift_n;
    logic [CNT_W-1:0]  r_target, r_cnt;
    logic [FILL_W-1:0] r_fill, w_fill_n;
    logic              r_z;
    logic              w_shift_en, w_match, w_hit_target, w_run_start, w_cfg_load;

    // Shift/match evaluation; an abort discards the bit presented with it.
    always_comb begin
        w_shift_n    = {r_shift[PAT_W-2:0], bus.w};
        w_fill_n     = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        w_shift_en   = (r_state == S_RUN) && !bus.abort && bus.w_valid;
        w_match      = w_shift_en && (w_fill_n == FILL_FULL) && (w_shift_n == r_pattern);
        // Widened compare so a saturated counter can never alias onto the target.
        w_hit_target = w_match && (r_target != '0) &&
                       (({1'b0, r_cnt} + (CNT_W+1)'(1)) == {1'b0, r_target});
        w_run_start  = (r_state != S_RUN) && bus.start;
        w_cfg_load   = (r_state != S_RUN) && bus.cfg_we;
    end

    // Next-state selection: abort beats target completion, start only outside RUN.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_n = S_RUN;
            S_RUN: begin
                if (bus.abort)       w_state_n = S_IDLE;
                else if (w_hit_target) w_state_n = S_DONE;
            end
            S_DONE:  if (bus.start) w_state_n = S_RUN;
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    // Config, shift window, fill level, match counter and match pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_target  <= '0;
            r_shift   <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_z       <= 1'b0;
        end else begin
            r_z <= w_match;
            if (w_cfg_load) begin
                r_pattern <= bus.cfg_pattern;
                r_target  <= bus.cfg_target;
            end
            if (w_run_start) begin
                r_shift <= '0;
                r_fill  <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_shift_n;
                r_fill  <= w_fill_n;
                if (w_match && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.z         = r_z;
    assign bus.match_cnt = r_cnt;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb/tb_pattern_match_ctrl.sv - directed self-checking bench for pattern_match_ctrl
module tb_pattern_match_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pattern_match_ctrl_if #(.PAT_W(4), .CNT_W(8)) pm_if ();

    pattern_match_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pm_if)
    );

    // Advance one rising edge; inputs set before, outputs sampled 1 ns after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pm_if.cfg_we = 0; pm_if.start = 0; pm_if.abort = 0;
        pm_if.w = 0; pm_if.w_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        pm_if.cfg_pattern = '0; pm_if.cfg_target = '0;
        reset = 1;
        step(); step();
        n_total++; if (pm_if.z !== 1'b0) $display("FAIL reset_z got=%b exp=0", pm_if.z); else n_pass++;
        n_total++; if (pm_if.match_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", pm_if.match_cnt); else n_pass++;
        n_total++; if (pm_if.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", pm_if.busy); else n_pass++;
        n_total++; if (pm_if.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", pm_if.done); else n_pass++;
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            pm_if.w = i[0]; pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== 1'b0) $display("FAIL idle_no_z[%0d] got=%b exp=0", i, pm_if.z); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_overlap();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_z = 7'b0001001;
        pm_if.cfg_we = 1; pm_if.cfg_pattern = 4'b1011; pm_if.cfg_target = 8'd0;
        step(); idle_inputs();
        pm_if.start = 1; step(); idle_inputs();
        n_total++; if (pm_if.busy !== 1'b1) $display("FAIL ovl_busy_start got=%b exp=1", pm_if.busy); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            pm_if.w = bits[6-i]; pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== exp_z[6-i]) $display("FAIL ovl_z[%0d] got=%b exp=%b", i, pm_if.z, exp_z[6-i]); else n_pass++;
        end
        idle_inputs();
        n_total++; if (pm_if.match_cnt !== 8'd2) $display("FAIL ovl_cnt got=%0d exp=2", pm_if.match_cnt); else n_pass++;
        n_total++; if (pm_if.busy !== 1'b1) $display("FAIL ovl_busy got=%b exp=1", pm_if.busy); else n_pass++;
    endtask

    task automatic test_target();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_z = 7'b0001001;
        pm_if.abort = 1; step(); idle_inputs();
        pm_if.cfg_we = 1; pm_if.cfg_pattern = 4'b1011; pm_if.cfg_target = 8'd2;
        step(); idle_inputs();
        pm_if.start = 1; step(); idle_inputs();
        n_total++; if (pm_if.match_cnt !== 8'd0) $display("FAIL tgt_cnt_clear got=%0d exp=0", pm_if.match_cnt); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            pm_if.w = bits[6-i]; pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== exp_z[6-i]) $display("FAIL tgt_z[%0d] got=%b exp=%b", i, pm_if.z, exp_z[6-i]); else n_pass++;
        end
        n_total++; if (pm_if.done !== 1'b1) $display("FAIL tgt_done got=%b exp=1", pm_if.done); else n_pass++;
        n_total++; if (pm_if.busy !== 1'b0) $display("FAIL tgt_busy got=%b exp=0", pm_if.busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pm_if.w = (i != 1); pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== 1'b0) $display("FAIL tgt_post_z[%0d] got=%b exp=0", i, pm_if.z); else n_pass++;
        end
        idle_inputs();
        n_total++; if (pm_if.match_cnt !== 8'd2) $display("FAIL tgt_cnt got=%0d exp=2", pm_if.match_cnt); else n_pass++;
        n_total++; if (pm_if.done !== 1'b1) $display("FAIL tgt_done_hold got=%b exp=1", pm_if.done); else n_pass++;
    endtask

    task automatic test_valid_gap();
        logic [4:0] bits  = 5'b10011;
        logic [4:0] vld   = 5'b11011;
        logic [4:0] exp_z = 5'b00001;
        pm_if.cfg_we = 1; pm_if.cfg_pattern = 4'b1011; pm_if.cfg_target = 8'd0;
        step(); idle_inputs();
        pm_if.start = 1; step(); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            pm_if.w = bits[4-i]; pm_if.w_valid = vld[4-i];
            step();
            n_total++; if (pm_if.z !== exp_z[4-i]) $display("FAIL gap_z[%0d] got=%b exp=%b", i, pm_if.z, exp_z[4-i]); else n_pass++;
        end
        idle_inputs();
        n_total++; if (pm_if.match_cnt !== 8'd1) $display("FAIL gap_cnt got=%0d exp=1", pm_if.match_cnt); else n_pass++;
    endtask

    task automatic test_abort_cfg();
        logic [3:0] bits  = 4'b1011;
        logic [3:0] exp_z = 4'b0001;
        // Window is 1011 with one match; 0,1,1 would complete another match.
        pm_if.w_valid = 1;
        pm_if.w = 0; step();
        pm_if.w = 1; step();
        pm_if.w = 1; pm_if.abort = 1; step();
        idle_inputs();
        n_total++; if (pm_if.z !== 1'b0) $display("FAIL abort_z got=%b exp=0", pm_if.z); else n_pass++;
        n_total++; if (pm_if.busy !== 1'b0 || pm_if.done !== 1'b0)
            $display("FAIL abort_idle got=busy%b/done%b exp=0/0", pm_if.busy, pm_if.done); else n_pass++;
        n_total++; if (pm_if.match_cnt !== 8'd1) $display("FAIL abort_cnt got=%0d exp=1", pm_if.match_cnt); else n_pass++;
        pm_if.start = 1; step(); idle_inputs();
        pm_if.cfg_we = 1; pm_if.cfg_pattern = 4'b0000; pm_if.cfg_target = 8'd1;
        step(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            pm_if.w = bits[3-i]; pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== exp_z[3-i]) $display("FAIL runcfg_z[%0d] got=%b exp=%b", i, pm_if.z, exp_z[3-i]); else n_pass++;
        end
        idle_inputs();
        n_total++; if (pm_if.busy !== 1'b1) $display("FAIL runcfg_busy got=%b exp=1", pm_if.busy); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic [6:0] bits  = 7'b0110110;
        logic [6:0] exp_z = 7'b0001001;
        reset = 1; step(); reset = 0;
        n_total++; if (pm_if.match_cnt !== 8'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", pm_if.match_cnt); else n_pass++;
        n_total++; if (pm_if.busy !== 1'b0 || pm_if.done !== 1'b0 || pm_if.z !== 1'b0)
            $display("FAIL mid_rst_flags got=busy%b/done%b/z%b exp=0/0/0", pm_if.busy, pm_if.done, pm_if.z); else n_pass++;
        pm_if.cfg_we = 1; pm_if.cfg_pattern = 4'b0110; pm_if.cfg_target = 8'd0; pm_if.start = 1;
        step(); idle_inputs();
        n_total++; if (pm_if.busy !== 1'b1) $display("FAIL newcfg_busy got=%b exp=1", pm_if.busy); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            pm_if.w = bits[6-i]; pm_if.w_valid = 1;
            step();
            n_total++; if (pm_if.z !== exp_z[6-i]) $display("FAIL newcfg_z[%0d] got=%b exp=%b", i, pm_if.z, exp_z[6-i]); else n_pass++;
        end
        idle_inputs();
        n_total++; if (pm_if.match_cnt !== 8'd2) $display("FAIL newcfg_cnt got=%0d exp=2", pm_if.match_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_target();
        test_valid_gap();
        test_abort_cfg();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
